// File: rtl/sudoku_pkg.sv
// Shared constants and types for the sudoku puzzle loader.
package sudoku_pkg;

  localparam int unsigned CELL_W = 9;
  localparam int unsigned NCELLS = 81;
  localparam int unsigned GRID_W = CELL_W * NCELLS;
  localparam int unsigned IDX_W  = 7;

  typedef enum logic [1:0] {
    StLoad,
    StFire,
    StRun,
    StReport
  } state_e;

  localparam logic [1:0] FailSolved  = 2'd0;
  localparam logic [1:0] FailSearch  = 2'd1;
  localparam logic [1:0] FailFormat  = 2'd2;
  localparam logic [1:0] FailTimeout = 2'd3;

endpackage

// File: rtl/sudoku_dec2hot.sv
// Decimal cell digit to 9-bit one-hot candidate encoder.
module sudoku_dec2hot import sudoku_pkg::*; #(
  parameter bit BLANK_ALL_ONES = 1'b1
) (
  input  logic [3:0]        digit_i,
  output logic [CELL_W-1:0] hot_o,
  output logic              illegal_o
);

  // Blank is either "all candidates open" or empty; 10..15 are flagged.
  always_comb begin
    hot_o     = '0;
    illegal_o = 1'b0;
    if (digit_i == 4'd0) begin
      hot_o = BLANK_ALL_ONES ? '1 : '0;
    end else if (digit_i <= 4'd9) begin
      hot_o = CELL_W'(1) << (digit_i - 4'd1);
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_loader.sv
// Streams 81 puzzle digits into a one-hot grid, launches the search and
// holds a status / cycle-count report until acknowledged.
module sudoku_loader import sudoku_pkg::*; #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT        = 0,
  parameter bit          BLANK_ALL_ONES = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [3:0]        cell_digit,
  input  logic              cell_last,
  output logic [GRID_W-1:0] inGrid,
  output logic              start,
  input  logic              done,
  input  logic              error,
  output logic              busy,
  output logic              report_valid,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  solve_cycles,
  input  logic              report_ack
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NCELLS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                fmt_q, fmt_d;
  logic [GRID_W-1:0]   grid_q, grid_d;
  logic [1:0]          fail_q, fail_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                rv_q, rv_d;
  logic                ready_q, ready_d;

  logic [CELL_W-1:0]   hot;
  logic                illegal;
  logic                hs;
  logic [9:0]          wr_msb;
  logic [CNT_W-1:0]    cyc_inc;

  sudoku_dec2hot #(
    .BLANK_ALL_ONES(BLANK_ALL_ONES)
  ) u_dec2hot (
    .digit_i  (cell_digit),
    .hot_o    (hot),
    .illegal_o(illegal)
  );

  assign hs      = cell_valid & ready_q;
  // Cell k occupies inGrid[728-9k -: 9]; cell 0 is the top slice.
  assign wr_msb  = 10'(GRID_W - 1) - 10'(CELL_W) * 10'(idx_q);
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fmt_d   = fmt_q;
    grid_d  = grid_q;
    fail_d  = fail_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      StLoad: begin
        if (hs) begin
          grid_d[wr_msb -: CELL_W] = hot;
          idx_d = idx_q + 1'b1;
          fmt_d = fmt_q | illegal;
          if (idx_q == LastIdx) begin
            if (fmt_q | illegal) begin
              state_d = StReport;
              fail_d  = FailFormat;
            end else begin
              state_d = StFire;
            end
          end else if (cell_last) begin
            // Short puzzle: never hand it to the search.
            fmt_d   = 1'b1;
            state_d = StReport;
            fail_d  = FailFormat;
          end
        end
      end
      StFire: begin
        cyc_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cyc_d = cyc_inc;
        if (error) begin
          state_d = StReport;
          fail_d  = FailSearch;
        end else if (done) begin
          state_d = StReport;
          fail_d  = FailSolved;
        end else if ((TIMEOUT != 0) && (cyc_inc >= CNT_W'(TIMEOUT))) begin
          state_d = StReport;
          fail_d  = FailTimeout;
        end
      end
      StReport: begin
        if (report_ack) begin
          state_d = StLoad;
          idx_d   = '0;
          fmt_d   = 1'b0;
          fail_d  = FailSolved;
        end
      end
      default: state_d = StLoad;
    endcase
    start_d = (state_d == StFire);
    busy_d  = (state_d == StFire) || (state_d == StRun);
    rv_d    = (state_d == StReport);
    ready_d = (state_d == StLoad);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StLoad;
      idx_q   <= '0;
      fmt_q   <= 1'b0;
      grid_q  <= '0;
      fail_q  <= FailSolved;
      cyc_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fmt_q   <= fmt_d;
      grid_q  <= grid_d;
      fail_q  <= fail_d;
      cyc_q   <= cyc_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      ready_q <= ready_d;
    end
  end

  assign cell_ready   = ready_q;
  assign inGrid       = grid_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign report_valid = rv_q;
  assign fail_code    = fail_q;
  assign solve_cycles = cyc_q;

endmodule

// File: tb/tb_sudoku_loader.sv
// Directed bench for sudoku_loader: one instance with default parameters,
// one with TIMEOUT=100 and blanks encoded as 9'h000.
module tb_sudoku_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_last, a_done, a_error, a_ack;
  logic [3:0]   a_digit;
  logic         a_ready, a_start, a_busy, a_rv;
  logic [728:0] a_grid;
  logic [1:0]   a_fc;
  logic [31:0]  a_cyc;
  logic         b_valid, b_last, b_done, b_error, b_ack;
  logic [3:0]   b_digit;
  logic         b_ready, b_start, b_busy, b_rv;
  logic [728:0] b_grid;
  logic [1:0]   b_fc;
  logic [31:0]  b_cyc;

  int checks = 0;
  int errors = 0;
  int a_starts = 0;
  int starts_before;
  int n;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_start === 1'b1) a_starts++;

  sudoku_loader u_dut_a (
    .clk(clk), .rst(rst), .cell_valid(a_valid), .cell_ready(a_ready),
    .cell_digit(a_digit), .cell_last(a_last), .inGrid(a_grid), .start(a_start),
    .done(a_done), .error(a_error), .busy(a_busy), .report_valid(a_rv),
    .fail_code(a_fc), .solve_cycles(a_cyc), .report_ack(a_ack)
  );

  sudoku_loader #(
    .CNT_W(32), .TIMEOUT(100), .BLANK_ALL_ONES(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .cell_valid(b_valid), .cell_ready(b_ready),
    .cell_digit(b_digit), .cell_last(b_last), .inGrid(b_grid), .start(b_start),
    .done(b_done), .error(b_error), .busy(b_busy), .report_valid(b_rv),
    .fail_code(b_fc), .solve_cycles(b_cyc), .report_ack(b_ack)
  );

  // Puzzle 1: (7k)%10, puzzle 2: (4k+3)%10; both contain blanks.
  function automatic logic [3:0] pz(input int p, input int k);
    if (p == 1) return 4'((k * 7) % 10);
    return 4'((k * 4 + 3) % 10);
  endfunction

  function automatic logic [8:0] enc(input logic [3:0] d, input bit ones);
    logic [8:0] r;
    r = 9'h000;
    if (d == 4'd0) r = ones ? 9'h1FF : 9'h000;
    else if (d <= 4'd9) r = 9'h001 << (d - 4'd1);
    return r;
  endfunction

  function automatic logic [3:0] hot2dec(input logic [8:0] h);
    for (int i = 0; i < 9; i++) if (h == (9'h001 << i)) return 4'(i + 1);
    return 4'd0;
  endfunction

  function automatic logic [8:0] cell_of(input logic [728:0] g, input int k);
    return g[728 - 9 * k -: 9];
  endfunction

  function automatic logic [728:0] exp_grid(input int p, input bit ones, input int bad_at);
    logic [728:0] g;
    g = '0;
    for (int k = 0; k < 81; k++) g[728 - 9 * k -: 9] = (k == bad_at) ? 9'h000 : enc(pz(p, k), ones);
    return g;
  endfunction

  task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic v, input logic [3:0] d, input logic l);
    if (sel) begin b_valid = v; b_digit = d; b_last = l; end
    else begin a_valid = v; a_digit = d; a_last = l; end
  endtask

  // Streams cells 0..last_at, cell_last on last_at; optional idle cycle between cells.
  task automatic load(input bit sel, input int p, input int last_at, input int bad_at,
                      input bit gap);
    for (int k = 0; k <= last_at; k++) begin
      logic [3:0] d;
      d = (k == bad_at) ? 4'd12 : pz(p, k);
      if (gap && k != 0) begin @(negedge clk); drv(sel, 1'b0, 4'd0, 1'b0); end
      @(negedge clk);
      drv(sel, 1'b1, d, k == last_at);
      @(posedge clk);
    end
    @(negedge clk);
    drv(sel, 1'b0, 4'd0, 1'b0);
  endtask

  // Called at the FIRE negedge; result is sampled on RUN cycle k.
  task automatic finish_run(input int k, input logic err);
    repeat (k) @(negedge clk);
    a_done = 1'b1;
    a_error = err;
    @(negedge clk);
    a_done = 1'b0;
    a_error = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge clk); a_ack = 1'b1;
    @(negedge clk); a_ack = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_start"}, 729'(a_start), 729'(0));
    chk({tag, "_busy"}, 729'(a_busy), 729'(0));
    chk({tag, "_rv"}, 729'(a_rv), 729'(0));
    chk({tag, "_fc"}, 729'(a_fc), 729'(0));
    chk({tag, "_cyc"}, 729'(a_cyc), 729'(0));
    chk({tag, "_grid"}, a_grid, 729'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drv(1'b0, 1'b0, 4'd0, 1'b0);
    drv(1'b1, 1'b0, 4'd0, 1'b0);
    a_done = 0; a_error = 0; a_ack = 0;
    b_done = 0; b_error = 0; b_ack = 0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst0");
    rst = 1'b1;
    @(negedge clk);
    chk("rst0_ready", 729'(a_ready), 729'(1));

    // Back-to-back load, solved after 50 RUN cycles.
    load(1'b0, 1, 80, -1, 1'b0);
    chk("t1_start", 729'(a_start), 729'(1));
    chk("t1_busy", 729'(a_busy), 729'(1));
    chk("t1_ready_off", 729'(a_ready), 729'(0));
    finish_run(50, 1'b0);
    chk("t1_rv", 729'(a_rv), 729'(1));
    chk("t1_fc", 729'(a_fc), 729'(0));
    chk("t1_cyc", 729'(a_cyc), 729'(50));
    chk("t1_cell0_blank", 729'(cell_of(a_grid, 0)), 729'(9'h1FF));
    chk("t1_cell1", 729'(cell_of(a_grid, 1)), 729'(9'h040));
    chk("t1_cell2_dec", 729'(hot2dec(cell_of(a_grid, 2))), 729'(4));
    chk("t1_grid", a_grid, exp_grid(1, 1'b1, -1));
    chk("t1_one_start", 729'(a_starts), 729'(1));
    ack_a();
    chk("t1_ack_ready", 729'(a_ready), 729'(1));
    chk("t1_ack_rv", 729'(a_rv), 729'(0));
    chk("t1_cyc_held", 729'(a_cyc), 729'(50));

    // Gapped load of a different puzzle; error and done together.
    load(1'b0, 2, 80, -1, 1'b1);
    chk("t2_start", 729'(a_start), 729'(1));
    finish_run(3, 1'b1);
    chk("t2_fc", 729'(a_fc), 729'(1));
    chk("t2_cyc", 729'(a_cyc), 729'(3));
    chk("t2_grid", a_grid, exp_grid(2, 1'b1, -1));
    ack_a();

    // Illegal digit at cell 40.
    starts_before = a_starts;
    load(1'b0, 1, 80, 40, 1'b0);
    chk("t3_rv", 729'(a_rv), 729'(1));
    chk("t3_fc", 729'(a_fc), 729'(2));
    chk("t3_busy", 729'(a_busy), 729'(0));
    chk("t3_cell40", 729'(cell_of(a_grid, 40)), 729'(9'h000));
    chk("t3_grid", a_grid, exp_grid(1, 1'b1, 40));
    @(negedge clk);
    chk("t3_no_start", 729'(a_starts), 729'(starts_before));
    ack_a();

    // Short puzzle ending at cell 10, then a full reload solves.
    load(1'b0, 2, 10, -1, 1'b0);
    chk("t4_rv", 729'(a_rv), 729'(1));
    chk("t4_fc", 729'(a_fc), 729'(2));
    chk("t4_cell10", 729'(cell_of(a_grid, 10)), 729'(enc(pz(2, 10), 1'b1)));
    chk("t4_no_start", 729'(a_starts), 729'(starts_before));
    ack_a();
    chk("t4_ack_fc", 729'(a_fc), 729'(0));
    load(1'b0, 1, 80, -1, 1'b0);
    chk("t4_start", 729'(a_start), 729'(1));
    finish_run(5, 1'b0);
    chk("t4_fc_ok", 729'(a_fc), 729'(0));
    chk("t4_cyc", 729'(a_cyc), 729'(5));
    chk("t4_grid", a_grid, exp_grid(1, 1'b1, -1));
    ack_a();

    // Reset during RUN.
    load(1'b0, 2, 80, -1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_a("rst_run");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_ready", 729'(a_ready), 729'(1));
    chk("rst_run_nostart", 729'(a_start), 729'(0));

    // done held across FIRE is ignored; first RUN cycle gives 1. Then reset in REPORT.
    load(1'b0, 1, 80, -1, 1'b0);
    a_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_done = 1'b0;
    chk("t5_rv", 729'(a_rv), 729'(1));
    chk("t5_cyc", 729'(a_cyc), 729'(1));
    rst = 1'b0;
    @(negedge clk);
    chk_reset_a("rst_rep");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rep_ready", 729'(a_ready), 729'(1));

    // Timeout instance, blanks as 9'h000, done never raised.
    load(1'b1, 1, 80, -1, 1'b0);
    chk("to_start", 729'(b_start), 729'(1));
    n = 0;
    while (b_rv !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 729'(n), 729'(101));
    chk("to_fc", 729'(b_fc), 729'(3));
    chk("to_cyc", 729'(b_cyc), 729'(100));
    chk("to_cell0_blank", 729'(cell_of(b_grid, 0)), 729'(9'h000));
    chk("to_grid", b_grid, exp_grid(1, 1'b0, -1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
